// File: rtl/dadda_mult_pipe.sv
// rtl/dadda_mult_pipe.sv - three-stage pipelined Dadda multiplier with Baugh-Wooley signed mode
module dadda_mult_pipe #(
   parameter int WIDTH  = 8,
   parameter int USE_BW = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW   = 2 * WIDTH;
   // Tallest column is WIDTH; one spare slot keeps the shift-append slices legal.
   localparam int MAXH = WIDTH + 1;
   localparam int DSEQ [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

   logic             en;
   logic             accept;
   logic             v1_q, v2_q, v3_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sgn_q;
   logic [PW-1:0]    row0_d, row1_d;
   logic [PW-1:0]    row0_q, row1_q;
   logic [PW-1:0]    p_d, p_q;

   // The whole pipe moves together; it only freezes when S3 holds an unaccepted product.
   assign en        = !v3_q || out_ready;
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign out_valid = v3_q;
   assign p         = p_q;
   assign p_d       = row0_q + row1_q;

   // Valid bits: the only reset state; bubbles shift along with data whenever en is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (en) begin
         v1_q <= accept;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // Datapath registers: S1 operands/mode, S2 carry-save pair, S3 final sum.
   always_ff @(posedge clk) begin
      if (en) begin
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= is_signed;
         end
         row0_q <= row0_d;
         row1_q <= row1_d;
         p_q    <= p_d;
      end
   end

   // Partial-product matrix from S1 registers, then Dadda reduction to two rows.
   // Each column is a small stack: bits are appended at bit 0 by shifting up and
   // consumed from bit 0 by shifting down, so the valid bits of a column always
   // sit in [cnt-1:0] with zeros above.
   always_comb begin
      logic [MAXH-1:0] col  [PW];
      logic [MAXH-1:0] ncol [PW];
      int              cnt  [PW];
      int              ncnt [PW];
      int              rem;
      int              d;
      logic            bw, pb, x, y, z;

      row0_d = '0;
      row1_d = '0;
      rem    = 0;
      d      = 0;
      pb     = 1'b0;
      x      = 1'b0;
      y      = 1'b0;
      z      = 1'b0;
      bw     = (USE_BW != 0) && sgn_q;
      for (int c = 0; c < PW; c++) begin
         col[c]  = '0;
         ncol[c] = '0;
         cnt[c]  = 0;
         ncnt[c] = 0;
      end

      // Cross terms with exactly one MSB operand bit are inverted in signed mode.
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pb = (a_q[j] & b_q[i]) ^ (bw & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            col[i+j] = {col[i+j][MAXH-2:0], pb};
            cnt[i+j] = cnt[i+j] + 1;
         end
      end
      // Baugh-Wooley correction constants; present structurally, valued by the mode.
      col[WIDTH]  = {col[WIDTH][MAXH-2:0], bw};
      cnt[WIDTH]  = cnt[WIDTH] + 1;
      col[PW-1]   = {col[PW-1][MAXH-2:0], bw};
      cnt[PW-1]   = cnt[PW-1] + 1;

      for (int k = 7; k >= 0; k--) begin
         if (DSEQ[k] < WIDTH) begin
            d = DSEQ[k];
            for (int c = 0; c < PW; c++) begin
               ncol[c] = '0;
               ncnt[c] = 0;
            end
            for (int c = 0; c < PW; c++) begin
               rem = cnt[c];
               // Carries from column c-1 already sit in ncol[c] and count toward height.
               for (int s = 0; s < MAXH; s++) begin
                  if ((rem + ncnt[c] > d) && (rem >= 2)) begin
                     x = col[c][0];
                     y = col[c][1];
                     if ((rem + ncnt[c] - d >= 2) && (rem >= 3)) begin
                        z      = col[c][2];
                        col[c] = col[c] >> 3;
                        rem    = rem - 3;
                     end else begin
                        z      = 1'b0;
                        col[c] = col[c] >> 2;
                        rem    = rem - 2;
                     end
                     ncol[c] = {ncol[c][MAXH-2:0], x ^ y ^ z};
                     ncnt[c] = ncnt[c] + 1;
                     if (c < PW - 1) begin
                        ncol[c+1] = {ncol[c+1][MAXH-2:0], (x & y) | (x & z) | (y & z)};
                        ncnt[c+1] = ncnt[c+1] + 1;
                     end
                  end
               end
               ncol[c] = (ncol[c] << rem) | col[c];
               ncnt[c] = ncnt[c] + rem;
            end
            for (int c = 0; c < PW; c++) begin
               col[c] = ncol[c];
               cnt[c] = ncnt[c];
            end
         end
      end

      for (int c = 0; c < PW; c++) begin
         row0_d[c] = col[c][0];
         row1_d[c] = col[c][1];
      end
   end

endmodule
